// File: rtl/pal_ctrl_pkg.sv
// Shared definitions for the pal_scan_arb palindrome-window arbiter.
// FSM encoding and result-count width helper.
package pal_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        RESULT = 2'b10
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w - 1);
    endfunction

endpackage

// File: rtl/pal3_window.sv
// Three-bit sliding window: two bits of history plus the incoming bit.
// hit flags a palindromic window once two history bits are loaded.
module pal3_window
    import pal_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic sample,
    output logic hit
);

    logic [1:0] win;
    logic [1:0] fill;

    assign hit = (fill == 2'd2) && (win[1] == sample);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win  <= '0;
            fill <= '0;
        end else if (clr) begin
            win  <= '0;
            fill <= '0;
        end else if (en) begin
            win <= {win[0], sample};
            if (fill != 2'd2)
                fill <= fill + 2'd1;
        end
    end

endmodule

// File: rtl/pal_scan_arb.sv
// Two-requester round-robin front end for the serial 3-bit palindrome detector.
// Build option PAL_FULLWORD_EN adds res_word_pal (word equals its bit-reverse).
module pal_scan_arb
    import pal_ctrl_pkg::*;
#(
    parameter  int W  = 8,
    localparam int CW = cnt_width(W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    input  logic [2*W-1:0] req_data,
    output logic [1:0]     req_ready,
    output logic           res_valid,
    output logic           res_id,
    output logic [CW-1:0]  res_count,
    input  logic           res_ready,
    output logic           busy,
    output logic           ser_bit
`ifdef PAL_FULLWORD_EN
    ,
    output logic           res_word_pal
`endif
);

    localparam int KW = $clog2(W);

    generate
        if (W < 3) begin : g_bad_width
            $error("pal_scan_arb: W must be >= 3");
        end
    endgenerate

    state_t         state;
    state_t         nxt;
    logic           last;
    logic           gnt;
    logic           take;
    logic [W-1:0]   word;
    logic [W-1:0]   sel_word;
    logic [KW-1:0]  k;
    logic           hit;

    assign sel_word  = gnt ? req_data[2*W-1:W] : req_data[W-1:0];
    assign res_valid = (state == RESULT);
    assign busy      = (state != IDLE);
    assign ser_bit   = (state == SHIFT) ? word[W-1] : 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    // Tie goes to whoever was not served last; `last` resets to 1 so 0 wins first.
    always_comb begin
        nxt       = state;
        req_ready = 2'b00;
        take      = 1'b0;
        gnt       = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    take      = 1'b1;
                    gnt       = (&req_valid) ? ~last : req_valid[1];
                    req_ready = gnt ? 2'b10 : 2'b01;
                    nxt       = SHIFT;
                end
            end
            SHIFT: begin
                if (k == KW'(W - 1))
                    nxt = RESULT;
            end
            RESULT: begin
                if (res_ready)
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    pal3_window u_win (
        .clk    (clk),
        .rst    (rst),
        .clr    (take),
        .en     (state == SHIFT),
        .sample (ser_bit),
        .hit    (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word      <= '0;
            k         <= '0;
            res_count <= '0;
            res_id    <= 1'b0;
            last      <= 1'b1;
        end else if (take) begin
            word      <= sel_word;
            k         <= '0;
            res_count <= '0;
            res_id    <= gnt;
        end else if (state == SHIFT) begin
            word <= word << 1;
            k    <= k + KW'(1);
            if (hit)
                res_count <= res_count + CW'(1);
        end else if (state == RESULT && res_ready) begin
            last <= res_id;
        end
    end

`ifdef PAL_FULLWORD_EN
    logic [W-1:0] rev;

    always_comb begin
        rev = '0;
        for (int i = 0; i < W; i++)
            rev[i] = sel_word[W-1-i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            res_word_pal <= 1'b0;
        else if (take)
            res_word_pal <= (rev == sel_word);
    end
`endif

endmodule

// File: doc/pal_scan_arb.md
Name: pal_scan_arb

Overview:
- Shares one 3-bit sliding-window palindrome detector between two requesters.
- Each requester submits a W-bit word over a valid/ready handshake. The block arbitrates round-robin, serialises the granted word MSB-first through the detector, and counts the palindromic 3-bit windows.
- The count is returned with the requester ID over a valid/ready result handshake.
- Sits between word-oriented producers and the serial palindrome datapath.

Parameters:
- W, 8, word width in bits; must be >= 3 (compile-time check fails elaboration otherwise).
- CW, $clog2(W-1), derived localparam: result count width; maximum count is W-2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  2  request valid, bit i = requester i.
- req_data  in  2*W  requester i word at [i*W +: W].
- req_ready  out  2  one-hot accept strobe; word accepted when req_valid[i] & req_ready[i].
- res_valid  out  1  result valid.
- res_id  out  1  requester the result belongs to.
- res_count  out  CW  number of palindromic windows in the word.
- res_ready  in  1  consumer accepts result.
- busy  out  1  high in SHIFT and RESULT.
- ser_bit  out  1  bit currently presented to the detector (debug).

Behaviour:
- Reset values (rst low, asynchronous): state=IDLE; res_valid=0, res_id=0, res_count=0, busy=0, req_ready=0, ser_bit=0; round-robin pointer favours requester 0; detector fill=0.
- FSM states: IDLE, SHIFT, RESULT.
- IDLE:
  - If any req_valid, grant one requester. If only one is valid, grant it. If both are valid, grant the one not granted last (requester 0 first after reset).
  - req_ready[g] is asserted combinationally this cycle only. The word is captured, bit counter and detector fill are cleared, and the state goes to SHIFT.
  - req_ready is never asserted outside IDLE.
- SHIFT, W cycles, k = 0..W-1:
  - ser_bit = captured word bit [W-1-k].
  - At each edge the bit shifts into the 3-bit window.
  - When fill >= 2 before the shift, count increments if {win[1], win[0], ser_bit} has first bit == third bit.
  - After the k = W-1 edge the state goes to RESULT.
  - Windows never span two words.
- RESULT:
  - res_valid=1 with res_id and res_count held stable until res_ready.
  - On the handshake edge: update pointer to res_id, go to IDLE, clear res_valid.
- Latency:
  - Accept at cycle 0; res_valid first high at cycle W+1.
  - Minimum spacing between accepts is W+2 cycles (res_ready tied high).
- Boundaries:
  - A requester dropping req_valid after its accept has no effect.
  - A req_valid change during SHIFT or RESULT is ignored until IDLE.
  - With res_ready held low the block stalls indefinitely in RESULT with outputs stable.
  - Count saturation is unreachable (max W-2 fits CW bits).
- Reset mid-operation: the in-flight word is discarded, no result is produced, and the pointer returns to favouring requester 0.

Optional Feature:
- Macro PAL_FULLWORD_EN.
- Defined: adds output res_word_pal (1 bit), valid with res_valid. It is 1 when the captured word equals its bit-reverse; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package pal_ctrl_pkg holds the FSM state encoding localparams (IDLE=2'b00, SHIFT=2'b01, RESULT=2'b10) and the function computing CW from W.
- Sub-module pal3_window holds the 3-bit shift window, the 2-bit fill counter (saturating at 2), a synchronous clear input, and a combinational hit output for the incoming bit.
- Arbiter, FSM, bit counter and result registers live in pal_scan_arb.

Test Plan:
- req0 sends 8'b1101_0010 alone -> req_ready=2'b01 at cycle 0; res_valid at cycle 9, res_id=0, res_count=3.
- req1 sends 8'b0101_0101 -> res_id=1, res_count=6; then req1 sends 8'b0011_0011 -> res_count=0.
- Both req_valid held high from reset with distinct words -> grants alternate 0,1,0,1; every result's res_id matches its grant; accepts are spaced 10 cycles apart.
- res_ready held low 5 cycles in RESULT -> res_valid, res_id and res_count stable; req_ready stays 0 despite pending req_valid.
- rst low during SHIFT cycle 4 -> busy=0 and res_valid=0 immediately; after release, both valid -> requester 0 granted and a fresh correct count returned.
- PAL_FULLWORD_EN defined:
  - 8'b1001_1001 -> res_word_pal=1, res_count=0.
  - 8'b1101_0010 -> res_word_pal=0.
